// File: rtl/dbus_arbiter_pkg.sv
// Shared types for the data-bus arbiter: bus request/response structs,
// arbiter FSM states and port indices.
package dbus_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } dbus_arb_state_t;

    localparam logic PORT_0 = 1'b0;
    localparam logic PORT_1 = 1'b1;

endpackage

// File: rtl/dbus_arbiter_select.sv
// Two-way priority picker: round-robin against the last grant, or fixed
// priority to port 0.
module dbus_arbiter_select
    import dbus_arbiter_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic valid_0,
    input  logic valid_1,
    input  logic last_grant,
    output logic winner
);

    always_comb begin
        winner = PORT_0;
        if (valid_0 && valid_1) begin
            winner = ROUND_ROBIN ? ~last_grant : PORT_0;
        end else if (valid_1) begin
            winner = PORT_1;
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Shares one data-bus channel between the Memory stage (port 0) and a
// secondary master (port 1), one outstanding transaction at a time.
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq_0,
    output dbus_resp_t dresp_0,
    input  dbus_req_t  dreq_1,
    output dbus_resp_t dresp_1,
    output dbus_req_t  dreq,
    input  dbus_resp_t dresp,
    output logic       busy,
    output logic       owner
);

    dbus_arb_state_t state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_grant_q, last_grant_d;

    logic      winner;
    logic      sel;
    logic      fwd_valid;
    logic      route;
    dbus_req_t sel_req;

    dbus_arbiter_select #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_select (
        .valid_0    (dreq_0.valid),
        .valid_1    (dreq_1.valid),
        .last_grant (last_grant_q),
        .winner     (winner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        sel          = owner_q;
        fwd_valid    = 1'b0;
        route        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                sel = winner;
                if (dreq_0.valid || dreq_1.valid) begin
                    fwd_valid = 1'b1;
                    route     = 1'b1;
                    owner_d   = winner;
                    if (dresp.addr_ok && dresp.data_ok) begin
                        last_grant_d = winner;
                    end else if (dresp.addr_ok) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                route = 1'b1;
                // Owner dropping valid is a cancel; last_grant keeps its value.
                if (!sel_req.valid) begin
                    state_d = ST_IDLE;
                end else begin
                    fwd_valid = 1'b1;
                    if (dresp.addr_ok && dresp.data_ok) begin
                        state_d      = ST_IDLE;
                        last_grant_d = owner_q;
                    end else if (dresp.addr_ok) begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                route = 1'b1;
                if (dresp.data_ok) begin
                    state_d      = ST_IDLE;
                    last_grant_d = owner_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sel_req = sel ? dreq_1 : dreq_0;

    always_comb begin
        dreq       = sel_req;
        dreq.valid = fwd_valid;
        dresp_0    = '0;
        dresp_1    = '0;
        if (route) begin
            if (sel) begin
                dresp_1 = dresp;
            end else begin
                dresp_0 = dresp;
            end
        end
        if (reset) begin
            dreq    = '0;
            dresp_0 = '0;
            dresp_1 = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= PORT_0;
            last_grant_q <= PORT_1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign owner = owner_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: a round-robin instance and a
// fixed-priority instance share one set of stimulus.
module tb_dbus_arbiter;
    import dbus_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  dreq_0, dreq_1;
    dbus_resp_t dresp;
    dbus_req_t  dreq, dreq_fp;
    dbus_resp_t dresp_0, dresp_1, dresp_0_fp, dresp_1_fp;
    logic       busy, owner, busy_fp, owner_fp;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    dbus_arbiter #(.ROUND_ROBIN(1'b1)) dut (
        .clk     (clk),
        .reset   (reset),
        .dreq_0  (dreq_0),
        .dresp_0 (dresp_0),
        .dreq_1  (dreq_1),
        .dresp_1 (dresp_1),
        .dreq    (dreq),
        .dresp   (dresp),
        .busy    (busy),
        .owner   (owner)
    );

    dbus_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
        .clk     (clk),
        .reset   (reset),
        .dreq_0  (dreq_0),
        .dresp_0 (dresp_0_fp),
        .dreq_1  (dreq_1),
        .dresp_1 (dresp_1_fp),
        .dreq    (dreq_fp),
        .dresp   (dresp),
        .busy    (busy_fp),
        .owner   (owner_fp)
    );

    task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic dbus_req_t mk_req(input logic [31:0] addr, input logic [3:0] strobe,
                                         input logic [31:0] data);
        dbus_req_t r;
        r.valid  = 1'b1;
        r.addr   = addr;
        r.size   = 3'd2;
        r.strobe = strobe;
        r.data   = data;
        return r;
    endfunction

    function automatic dbus_resp_t mk_resp(input logic a, input logic d, input logic [31:0] data);
        dbus_resp_t r;
        r.addr_ok = a;
        r.data_ok = d;
        r.data    = data;
        return r;
    endfunction

    // Each cycle: drive just after the falling edge, sample 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        reset  = 1'b1;
        dreq_0 = '0;
        dreq_1 = '0;
        dresp  = '0;
        next_cycle();
        reset = 1'b0;
    endtask

    dbus_req_t  ld0, rq0, rq1, st0;
    dbus_resp_t exp_r;

    initial begin
        reset  = 1'b1;
        dreq_0 = '0;
        dreq_1 = '0;
        dresp  = '0;

        // Reset state: forwarding and responses forced to zero.
        next_cycle();
        dreq_0 = mk_req(32'h8000_0000, 4'h0, 32'h0);
        dresp  = mk_resp(1'b1, 1'b1, 32'hCAFE_0000);
        settle();
        check("rst_dreq", dreq, '0);
        check("rst_dresp0", dresp_0, '0);
        check("rst_dresp1", dresp_1, '0);
        next_cycle();
        dresp = '0;
        settle();
        check("rst_busy", busy, 1'b0);
        check("rst_owner", owner, 1'b0);

        // Single load on port 0.
        do_reset();
        ld0 = mk_req(32'h8000_0010, 4'h0, 32'h0);
        next_cycle(); dreq_0 = ld0; settle();
        check("ld_c0_dreq", dreq, ld0);
        check("ld_c0_dresp1", dresp_1, '0);
        check("ld_c0_busy", busy, 1'b0);
        next_cycle(); settle();
        check("ld_c1_dreq", dreq, ld0);
        check("ld_c1_busy", busy, 1'b1);
        next_cycle(); dresp = mk_resp(1'b1, 1'b0, 32'h0); settle();
        check("ld_c2_dreq", dreq, ld0);
        check("ld_c2_addr_ok", dresp_0.addr_ok, 1'b1);
        check("ld_c2_dresp1", dresp_1, '0);
        next_cycle(); dreq_0 = '0; dresp = '0; settle();
        check("ld_c3_valid", dreq.valid, 1'b0);
        check("ld_c3_busy", busy, 1'b1);
        next_cycle(); dresp = mk_resp(1'b0, 1'b1, 32'hDEAD_BEEF); settle();
        exp_r = mk_resp(1'b0, 1'b1, 32'hDEAD_BEEF);
        check("ld_c4_dresp0", dresp_0, exp_r);
        check("ld_c4_dresp1", dresp_1, '0);
        next_cycle(); dresp = '0; settle();
        check("ld_c5_busy", busy, 1'b0);
        check("ld_c5_owner", owner, 1'b0);

        // Both valid, single-cycle completions: RR alternates, FP sticks to 0.
        do_reset();
        rq0 = mk_req(32'h0000_1000, 4'h0, 32'h0);
        rq1 = mk_req(32'h0000_2000, 4'h0, 32'h0);
        for (int unsigned i = 0; i < 4; i++) begin
            next_cycle();
            dreq_0 = rq0;
            dreq_1 = rq1;
            dresp  = mk_resp(1'b1, 1'b1, 32'h0);
            settle();
            check($sformatf("rr_grant%0d", i), dreq.addr, (i % 2 == 0) ? rq0.addr : rq1.addr);
            check($sformatf("rr_dok1_%0d", i), dresp_1.data_ok, (i % 2 == 1) ? 1'b1 : 1'b0);
            if (i < 3) begin
                check($sformatf("fp_grant%0d", i), dreq_fp.addr, rq0.addr);
                check($sformatf("fp_dok0_%0d", i), dresp_0_fp.data_ok, 1'b1);
            end
            check($sformatf("rr_busy%0d", i), busy, 1'b0);
        end

        // Port 1 in ST_DATA stalls port 0's store until data_ok.
        do_reset();
        st0 = mk_req(32'h0000_0010, 4'hF, 32'h0000_1234);
        next_cycle(); dreq_1 = rq1; dresp = mk_resp(1'b1, 1'b0, 32'h0); settle();
        check("st_c0_addr", dreq.addr, rq1.addr);
        next_cycle(); dreq_1 = '0; dreq_0 = st0; dresp = '0; settle();
        check("st_c1_valid", dreq.valid, 1'b0);
        check("st_c1_owner", owner, 1'b1);
        check("st_c1_busy", busy, 1'b1);
        next_cycle(); settle();
        check("st_c2_valid", dreq.valid, 1'b0);
        next_cycle(); dresp = mk_resp(1'b0, 1'b1, 32'h0000_0055); settle();
        check("st_c3_valid", dreq.valid, 1'b0);
        check("st_c3_dok1", dresp_1.data_ok, 1'b1);
        check("st_c3_dresp0", dresp_0, '0);
        next_cycle(); dresp = mk_resp(1'b1, 1'b1, 32'h0); settle();
        check("st_c4_dreq", dreq, st0);
        check("st_c4_aok0", dresp_0.addr_ok, 1'b1);
        check("st_c4_busy", busy, 1'b0);

        // Cancel in ST_ADDR: valid drops, then port 1 is granted.
        do_reset();
        next_cycle(); dreq_0 = rq0; dreq_1 = rq1; dresp = '0; settle();
        check("cx_c0_addr", dreq.addr, rq0.addr);
        next_cycle(); dreq_0 = '0; settle();
        check("cx_c1_valid", dreq.valid, 1'b0);
        check("cx_c1_busy", busy, 1'b1);
        next_cycle(); dresp = mk_resp(1'b1, 1'b1, 32'h0); settle();
        check("cx_c2_valid", dreq.valid, 1'b1);
        check("cx_c2_addr", dreq.addr, rq1.addr);
        check("cx_c2_aok1", dresp_1.addr_ok, 1'b1);
        check("cx_c2_busy", busy, 1'b0);

        // Reset in ST_DATA discards the transaction.
        do_reset();
        next_cycle(); dreq_1 = rq1; dresp = mk_resp(1'b1, 1'b0, 32'h0); settle();
        check("rd_c0_addr", dreq.addr, rq1.addr);
        next_cycle(); dreq_1 = '0; reset = 1'b1; dresp = mk_resp(1'b0, 1'b1, 32'h7777_7777); settle();
        check("rd_c1_busy", busy, 1'b1);
        check("rd_c1_dresp1", dresp_1, '0);
        next_cycle(); reset = 1'b0; settle();
        check("rd_c2_busy", busy, 1'b0);
        check("rd_c2_owner", owner, 1'b0);
        check("rd_c2_dresp0", dresp_0, '0);
        check("rd_c2_dresp1", dresp_1, '0);

        // Same-cycle addr_ok/data_ok in ST_IDLE: back-to-back grant.
        do_reset();
        next_cycle(); dreq_0 = rq0; dresp = mk_resp(1'b1, 1'b1, 32'h0); settle();
        check("bb_c0_busy", busy, 1'b0);
        check("bb_c0_dok0", dresp_0.data_ok, 1'b1);
        next_cycle(); dreq_0 = st0; dresp = '0; settle();
        check("bb_c1_busy", busy, 1'b0);
        check("bb_c1_dreq", dreq, st0);
        next_cycle(); settle();
        check("bb_c2_busy", busy, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
